branch_redirect_ctrl: RTL and testbench

Sequences the fetch-side consequences of a resolved branch in the 6-stage core. It sits between the EX-stage Branch unit and the pre-IF/IF stages. It counts in-flight instruction-SRAM fetches and issues a one-cycle flush on a taken branch. It then holds a redirect request until pre-IF's request to the target is accepted, and marks responses of cancelled wrong-path fetches for discard.

---
 rtl/branch_redirect_ctrl_pkg.sv | 17 +
 rtl/branch_redirect_ctrl_fetch_outst_cnt.sv | 55 +++++
 rtl/branch_redirect_ctrl.sv | 158 +++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller.
package branch_redirect_ctrl_pkg;

  // Width of the redirect FSM state encoding.
  localparam int REDIR_ST_LEN = 1;

  // Default limit on in-flight instruction-SRAM fetches.
  localparam int MAX_OUTST_DEF = 2;

  // IDLE: fetch follows the sequential path.
  // REDIR: a taken target waits for pre-IF to get its request accepted.
  typedef enum logic [REDIR_ST_LEN-1:0] {
    REDIR_ST_IDLE  = 1'b0,
    REDIR_ST_REDIR = 1'b1
  } redir_state_t;

endpackage

// File: rtl/branch_redirect_ctrl_fetch_outst_cnt.sv
// Saturating up/down counter for in-flight fetch requests. It holds at MAX
// on an unmatched increment and at 0 on an unmatched decrement. Both of those
// cases are protocol violations upstream.
module fetch_outst_cnt #(
  parameter int MAX = 2,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic [W-1:0] value_nx
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE_V = W'(1);
  localparam logic [W-1:0] ZERO_V = W'(0);

  logic [W-1:0] value_r;
  logic [W-1:0] value_nx_s;

  // Next count: simultaneous inc/dec cancel; saturate at both ends.
  always_comb begin
    value_nx_s = value_r;
    if (inc && !dec) begin
      if (value_r < MAX_V) begin
        value_nx_s = value_r + ONE_V;
      end else begin
        value_nx_s = value_r;
      end
    end else if (dec && !inc) begin
      if (value_r != ZERO_V) begin
        value_nx_s = value_r - ONE_V;
      end else begin
        value_nx_s = value_r;
      end
    end else begin
      value_nx_s = value_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_r <= ZERO_V;
    end else begin
      value_r <= value_nx_s;
    end
  end

  assign value    = value_r;
  assign value_nx = value_nx_s;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Fetch-side redirect sequencing for a resolved EX-stage branch. A taken
// branch flushes IF/ID, holds the target until pre-IF's request is accepted,
// and marks responses of wrong-path fetches already in flight for discard.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int MAX_OUTST = MAX_OUTST_DEF,
  parameter int CNT_W     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid_i,
  input  logic             br_taken_i,
  input  logic [31:0]      br_target_i,
  input  logic             fetch_req_i,
  input  logic             fetch_addr_ok_i,
  input  logic             fetch_data_ok_i,
  output logic             fetch_allow_o,
  output logic             flush_o,
  output logic             redir_valid_o,
  output logic [31:0]      redir_pc_o,
  output logic             resp_discard_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             busy_o,
  output logic [31:0]      redir_cnt_o
);

  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_V = CNT_W'(0);

  logic             acc_s;
  logic             take_s;
  logic [CNT_W-1:0] outst_s;
  logic [CNT_W-1:0] outst_nx_s;
  logic [CNT_W-1:0] cancel_r;
  logic [31:0]      target_r;
  logic [31:0]      redir_cnt_r;
  redir_state_t     state_r;
  redir_state_t     state_nx_s;

  assign acc_s  = fetch_req_i & fetch_addr_ok_i;
  assign take_s = br_valid_i & br_taken_i;

  fetch_outst_cnt #(
    .MAX (MAX_OUTST),
    .W   (CNT_W)
  ) u_outst (
    .clk      (clk),
    .reset    (reset),
    .inc      (acc_s),
    .dec      (fetch_data_ok_i),
    .value    (outst_s),
    .value_nx (outst_nx_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= REDIR_ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state: a take always (re)enters REDIR. Otherwise an accepted
  // request in REDIR is the redirect fetch and ends it.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      REDIR_ST_IDLE: begin
        if (take_s) begin
          state_nx_s = REDIR_ST_REDIR;
        end else begin
          state_nx_s = REDIR_ST_IDLE;
        end
      end
      REDIR_ST_REDIR: begin
        if (take_s) begin
          state_nx_s = REDIR_ST_REDIR;
        end else if (acc_s) begin
          state_nx_s = REDIR_ST_IDLE;
        end else begin
          state_nx_s = REDIR_ST_REDIR;
        end
      end
      default: begin
        state_nx_s = REDIR_ST_IDLE;
      end
    endcase
  end

  // FSM outputs: the redirect is visible only while REDIR is held.
  always_comb begin
    redir_valid_o = 1'b0;
    redir_pc_o    = 32'h0000_0000;
    case (state_r)
      REDIR_ST_IDLE: begin
        redir_valid_o = 1'b0;
        redir_pc_o    = 32'h0000_0000;
      end
      REDIR_ST_REDIR: begin
        redir_valid_o = 1'b1;
        redir_pc_o    = target_r;
      end
      default: begin
        redir_valid_o = 1'b0;
        redir_pc_o    = 32'h0000_0000;
      end
    endcase
  end

  // Capture the branch target on every take; the latest branch wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_r <= 32'h0000_0000;
    end else if (take_s) begin
      target_r <= br_target_i;
    end else begin
      target_r <= target_r;
    end
  end

  // Wrong-path response counter. On take, everything still in flight after
  // this cycle is owed, including a request accepted in the same cycle.
  // The redirect fetch is never counted, so its response follows the owed
  // ones because inst-SRAM returns responses in order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cancel_r <= ZERO_V;
    end else if (take_s) begin
      cancel_r <= outst_nx_s;
    end else if (fetch_data_ok_i && (cancel_r != ZERO_V)) begin
      cancel_r <= cancel_r - ONE_V;
    end else begin
      cancel_r <= cancel_r;
    end
  end

  // Count of taken redirects since reset; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redir_cnt_r <= 32'h0000_0000;
    end else if (take_s) begin
      redir_cnt_r <= redir_cnt_r + 32'h0000_0001;
    end else begin
      redir_cnt_r <= redir_cnt_r;
    end
  end

  assign fetch_allow_o  = (outst_s < MAX_V) | fetch_data_ok_i;
  assign flush_o        = take_s;
  assign resp_discard_o = fetch_data_ok_i & (cancel_r != ZERO_V);
  assign outstanding_o  = outst_s;
  assign busy_o         = (state_r == REDIR_ST_REDIR) | (cancel_r != ZERO_V);
  assign redir_cnt_o    = redir_cnt_r;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with hand-computed expectations.
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        reset;
  logic        br_valid_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        fetch_req_i;
  logic        fetch_addr_ok_i;
  logic        fetch_data_ok_i;
  logic        fetch_allow_o;
  logic        flush_o;
  logic        redir_valid_o;
  logic [31:0] redir_pc_o;
  logic        resp_discard_o;
  logic [1:0]  outstanding_o;
  logic        busy_o;
  logic [31:0] redir_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  branch_redirect_ctrl #(.MAX_OUTST(2), .CNT_W(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .br_valid_i      (br_valid_i),
    .br_taken_i      (br_taken_i),
    .br_target_i     (br_target_i),
    .fetch_req_i     (fetch_req_i),
    .fetch_addr_ok_i (fetch_addr_ok_i),
    .fetch_data_ok_i (fetch_data_ok_i),
    .fetch_allow_o   (fetch_allow_o),
    .flush_o         (flush_o),
    .redir_valid_o   (redir_valid_o),
    .redir_pc_o      (redir_pc_o),
    .resp_discard_o  (resp_discard_o),
    .outstanding_o   (outstanding_o),
    .busy_o          (busy_o),
    .redir_cnt_o     (redir_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    br_valid_i      = 1'b0;
    br_taken_i      = 1'b0;
    br_target_i     = 32'h0000_0000;
    fetch_req_i     = 1'b0;
    fetch_addr_ok_i = 1'b0;
    fetch_data_ok_i = 1'b0;
  endtask

  // Apply this cycle's inputs and let combinational outputs settle.
  task automatic drive(input logic take, input logic [31:0] tgt, input logic acc, input logic dok);
    br_valid_i      = take;
    br_taken_i      = take;
    br_target_i     = tgt;
    fetch_req_i     = acc;
    fetch_addr_ok_i = acc;
    fetch_data_ok_i = dok;
    #1;
  endtask

  // Clock edge, then idle inputs and settle before checking registered state.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #12;
    check("rst_allow", {31'd0, fetch_allow_o}, 32'd1);
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check("rst_rvalid", {31'd0, redir_valid_o}, 32'd0);
    check("rst_pc", redir_pc_o, 32'd0);
    check("rst_outst", {30'd0, outstanding_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_cnt", redir_cnt_o, 32'd0);
    reset = 1'b1;
    cyc();

    // Simple redirect from idle.
    drive(1'b1, 32'h1C00_0100, 1'b0, 1'b0);
    check("t1_flush_c0", {31'd0, flush_o}, 32'd1);
    check("t1_rvalid_c0", {31'd0, redir_valid_o}, 32'd0);
    cyc();
    check("t1_flush_c1", {31'd0, flush_o}, 32'd0);
    check("t1_rvalid_c1", {31'd0, redir_valid_o}, 32'd1);
    check("t1_pc_c1", redir_pc_o, 32'h1C00_0100);
    check("t1_busy_c1", {31'd0, busy_o}, 32'd1);
    cyc();
    check("t1_rvalid_c2", {31'd0, redir_valid_o}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("t1_rvalid_c3", {31'd0, redir_valid_o}, 32'd1);
    cyc();
    check("t1_rvalid_c4", {31'd0, redir_valid_o}, 32'd0);
    check("t1_pc_c4", redir_pc_o, 32'd0);
    check("t1_busy_c4", {31'd0, busy_o}, 32'd0);
    check("t1_cnt_c4", redir_cnt_o, 32'd1);
    check("t1_outst_c4", {30'd0, outstanding_o}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t1_disc", {31'd0, resp_discard_o}, 32'd0);
    cyc();
    check("t1_outst_end", {30'd0, outstanding_o}, 32'd0);

    // Fill to MAX_OUTST, then cancel two in-flight fetches.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cyc();
    check("t2_outst_full", {30'd0, outstanding_o}, 32'd2);
    check("t2_allow_full", {31'd0, fetch_allow_o}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t2_allow_dok", {31'd0, fetch_allow_o}, 32'd1);
    check("t2_disc_none", {31'd0, resp_discard_o}, 32'd0);
    cyc();
    check("t2_outst_1", {30'd0, outstanding_o}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 32'h1C00_0300, 1'b0, 1'b0);
    check("t2_flush", {31'd0, flush_o}, 32'd1);
    cyc();
    check("t2_busy", {31'd0, busy_o}, 32'd1);
    check("t2_cnt", redir_cnt_o, 32'd2);
    check("t2_outst_2", {30'd0, outstanding_o}, 32'd2);
    check("t2_pc", redir_pc_o, 32'h1C00_0300);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t2_disc_a", {31'd0, resp_discard_o}, 32'd1);
    cyc();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("t2_disc_b", {31'd0, resp_discard_o}, 32'd1);
    cyc();
    check("t2_rvalid_done", {31'd0, redir_valid_o}, 32'd0);
    check("t2_busy_done", {31'd0, busy_o}, 32'd0);
    check("t2_outst_redir", {30'd0, outstanding_o}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t2_disc_redir", {31'd0, resp_discard_o}, 32'd0);
    cyc();

    // Take and acc in the same cycle with one already in flight.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 32'h1C00_0100, 1'b1, 1'b0);
    check("t3_flush", {31'd0, flush_o}, 32'd1);
    cyc();
    check("t3_outst", {30'd0, outstanding_o}, 32'd2);
    check("t3_rvalid", {31'd0, redir_valid_o}, 32'd1);
    check("t3_cnt", redir_cnt_o, 32'd3);

    // Override in REDIR with acc+data_ok in the same cycle.
    drive(1'b1, 32'h1C00_0200, 1'b1, 1'b1);
    check("t5_flush", {31'd0, flush_o}, 32'd1);
    check("t5_disc", {31'd0, resp_discard_o}, 32'd1);
    check("t5_allow", {31'd0, fetch_allow_o}, 32'd1);
    cyc();
    check("t5_rvalid", {31'd0, redir_valid_o}, 32'd1);
    check("t5_pc", redir_pc_o, 32'h1C00_0200);
    check("t5_cnt", redir_cnt_o, 32'd4);
    check("t5_outst", {30'd0, outstanding_o}, 32'd2);
    check("t5_flush_off", {31'd0, flush_o}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t5_disc_a", {31'd0, resp_discard_o}, 32'd1);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t5_disc_b", {31'd0, resp_discard_o}, 32'd1);
    cyc();
    check("t5_outst_0", {30'd0, outstanding_o}, 32'd0);
    check("t5_busy_redir", {31'd0, busy_o}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cyc();
    check("t5_busy_done", {31'd0, busy_o}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t5_disc_redir", {31'd0, resp_discard_o}, 32'd0);
    cyc();

    // Not-taken branch: nothing changes.
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    br_valid_i  = 1'b1;
    br_target_i = 32'hDEAD_BEEF;
    #1;
    check("t4_flush", {31'd0, flush_o}, 32'd0);
    cyc();
    check("t4_rvalid", {31'd0, redir_valid_o}, 32'd0);
    check("t4_cnt", redir_cnt_o, 32'd4);
    check("t4_outst", {30'd0, outstanding_o}, 32'd0);
    check("t4_busy", {31'd0, busy_o}, 32'd0);

    // Async reset while in REDIR with cancel=1.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 32'h1C00_0400, 1'b0, 1'b0);
    cyc();
    check("t6_busy_pre", {31'd0, busy_o}, 32'd1);
    check("t6_rvalid_pre", {31'd0, redir_valid_o}, 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rvalid", {31'd0, redir_valid_o}, 32'd0);
    check("t6_pc", redir_pc_o, 32'd0);
    check("t6_busy", {31'd0, busy_o}, 32'd0);
    check("t6_outst", {30'd0, outstanding_o}, 32'd0);
    check("t6_cnt", redir_cnt_o, 32'd0);
    check("t6_allow", {31'd0, fetch_allow_o}, 32'd1);
    cyc();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t6_disc_after", {31'd0, resp_discard_o}, 32'd0);
    idle_inputs();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
